stack_pointer_unit: RTL

Holds the architectural stack pointer and sequences the multi-word stack transfers for interrupt entry, RTI and RET. Sits directly upstream of the memory-stage stack handler:
- Drives the handler's `sp_in`, `mem_write_int`, `rti_pop` and `ret_pop`.
- Captures the handler's `modified_sp` as the next SP.

Stalls the pipeline front end while a multi-word sequence is in progress.

---
 rtl/stack_pointer_unit.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/stack_pointer_unit.sv
// stack_pointer_unit
//
// Holds the architectural stack pointer. Sequences the multi-word stack
// transfers for interrupt entry (push PC high, PC low, flags), RTI (pop
// flags, PC low, PC high) and RET (pop PC low, PC high). It drives the
// memory-stage stack handler and takes that handler's modified_sp as the
// next SP.
//
// Optional feature: define STACK_BOUNDS_CHECK_EN to enable SP bounds
// checking. When it is enabled:
//   - A push at SP_LIMIT, or a pop at SP_RESET, leaves SP unchanged and
//     sets the sticky stack_fault.
//   - The SP_LIMIT parameter exists only in this build.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   stall             memory-stage stall; freezes FSM, SP, pending, fault
//   sp_update/sp_push ordinary PUSH/POP/CALL commit in IDLE (push when 1)
//   int_req           interrupt entry request (level)
//   rti_req, ret_req  RTI / RET reached memory stage (pulses)
//   modified_sp       next SP computed by the stack handler
//   sp_out            registered SP to the handler's sp_in
//   mem_write_int     interrupt push strobe
//   rti_pop, ret_pop  pop strobes
//   word_sel          0 = PC high, 1 = PC low, 2 = flags
//   busy              sequence active or request pending; front end stalls
//   seq_done          pulse on the edge that leaves the last word
//   int_ack           pulse on the edge that takes IDLE -> PUSH0
//   stack_fault       sticky bounds violation
module stack_pointer_unit #(
    parameter logic [31:0] SP_RESET = 32'h00000FFF
`ifdef STACK_BOUNDS_CHECK_EN
    ,
    parameter logic [31:0] SP_LIMIT = 32'h00000800
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        sp_update,
    input  logic        sp_push,
    input  logic        int_req,
    input  logic        rti_req,
    input  logic        ret_req,
    input  logic [31:0] modified_sp,
    output logic [31:0] sp_out,
    output logic        mem_write_int,
    output logic        rti_pop,
    output logic        ret_pop,
    output logic [1:0]  word_sel,
    output logic        busy,
    output logic        seq_done,
    output logic        int_ack,
    output logic        stack_fault
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PUSH0 = 3'd1,
        PUSH1 = 3'd2,
        PUSH2 = 3'd3,
        POP0  = 3'd4,
        POP1  = 3'd5,
        POP2  = 3'd6
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  pend_reg, pend_next;      // {int, rti, ret}
    logic        ret_mode_reg, ret_mode_next;
    logic [31:0] sp_reg;
    logic [2:0]  req_vec, cand;
    logic        in_push, in_pop, sp_commit;

    assign req_vec = {int_req, rti_req, ret_req};
    // In IDLE, pending and fresh requests compete under one priority order.
    assign cand    = pend_reg | req_vec;

    // Next-state, pending and completion pulses.
    always_comb begin
        state_next    = state_reg;
        pend_next     = pend_reg | req_vec;
        ret_mode_next = ret_mode_reg;
        int_ack       = 1'b0;
        seq_done      = 1'b0;
        unique case (state_reg)
            IDLE: begin
                pend_next = 3'b000;
                if (cand[2]) begin
                    state_next = PUSH0;
                    int_ack    = 1'b1;
                    pend_next  = cand & 3'b011;
                end else if (cand[1]) begin
                    state_next    = POP0;
                    ret_mode_next = 1'b0;
                    pend_next     = cand & 3'b001;
                end else if (cand[0]) begin
                    // RET skips the flags word and starts at PC low.
                    state_next    = POP1;
                    ret_mode_next = 1'b1;
                end
            end
            PUSH0: state_next = PUSH1;
            PUSH1: state_next = PUSH2;
            PUSH2: begin
                state_next = IDLE;
                seq_done   = 1'b1;
            end
            POP0:  state_next = POP1;
            POP1:  state_next = POP2;
            POP2: begin
                state_next = IDLE;
                seq_done   = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        // A stall freezes everything. The pulses wait for the edge that
        // actually advances the FSM.
        if (stall) begin
            state_next    = state_reg;
            pend_next     = pend_reg;
            ret_mode_next = ret_mode_reg;
            int_ack       = 1'b0;
            seq_done      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            pend_reg     <= 3'b000;
            ret_mode_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pend_reg     <= pend_next;
            ret_mode_reg <= ret_mode_next;
        end
    end

    // Moore decode of the strobes and word selector.
    assign in_push       = (state_reg == PUSH0) || (state_reg == PUSH1) ||
                           (state_reg == PUSH2);
    assign in_pop        = (state_reg == POP0) || (state_reg == POP1) ||
                           (state_reg == POP2);
    assign mem_write_int = in_push;
    assign rti_pop       = in_pop && !ret_mode_reg;
    assign ret_pop       = in_pop && ret_mode_reg;
    assign busy          = (state_reg != IDLE) || (pend_reg != 3'b000);

    always_comb begin
        word_sel = 2'd0;
        unique case (state_reg)
            PUSH1, POP1: word_sel = 2'd1;
            PUSH2, POP0: word_sel = 2'd2;
            default:     word_sel = 2'd0;
        endcase
    end

    // A sequence word commits every cycle. An ordinary update commits
    // only in IDLE; it is ignored while a sequence runs.
    assign sp_commit = (state_reg != IDLE) || sp_update;

`ifdef STACK_BOUNDS_CHECK_EN
    logic fault_reg;
    logic push_commit, bound_hit;

    assign push_commit = in_push || ((state_reg == IDLE) && sp_push);
    assign bound_hit   = push_commit ? (sp_reg == SP_LIMIT)
                                     : (sp_reg == SP_RESET);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_reg    <= SP_RESET;
            fault_reg <= 1'b0;
        end else if (!stall && sp_commit) begin
            if (bound_hit) begin
                fault_reg <= 1'b1;
            end else begin
                sp_reg <= modified_sp;
            end
        end
    end

    assign stack_fault = fault_reg;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_reg <= SP_RESET;
        end else if (!stall && sp_commit) begin
            sp_reg <= modified_sp;
        end
    end

    assign stack_fault = 1'b0;
`endif

    assign sp_out = sp_reg;

endmodule
